// File: rtl/seq_mod3_pkg.sv
// Shared types and residue arithmetic for the mod-3 padded serializer.
// The pad for residue r makes (payload*4 + pad) divisible by 3.
package seq_mod3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } state_t;

  typedef logic [1:0] residue_t;

  // Packed pad table indexed by residue: p[0]=0, p[1]=2, p[2]=1.
  localparam logic [5:0] PAD_LUT = {2'd1, 2'd2, 2'd0};

  function automatic residue_t residue_step(input residue_t r, input logic b);
    case (r)
      2'd1:    return b ? 2'd0 : 2'd2;
      2'd2:    return b ? 2'd2 : 2'd1;
      default: return b ? 2'd1 : 2'd0;  // r=3 is unreachable and treated as 0
    endcase
  endfunction

  function automatic residue_t pad_lookup(input residue_t r);
    return (r == 2'd3) ? 2'd0 : PAD_LUT[{r, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/seq_mod3_serializer_if.sv
// Parallel-in handshake plus serial-out bus of the serializer.
// SEQ_MOD3_RES_OUT_EN adds the payload residue report signals.
interface seq_mod3_serializer_if #(
  parameter int W = 8
);
  import seq_mod3_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         ser_data;
  logic         ser_valid;
  logic         ser_last;
  logic         busy;
`ifdef SEQ_MOD3_RES_OUT_EN
  residue_t     res_out;
  logic         res_valid;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_data, ser_valid, ser_last, busy, res_out, res_valid
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_data, ser_valid, ser_last, busy, res_out, res_valid
  );
`else
  modport master (
    output in_valid, in_data,
    input  in_ready, ser_data, ser_valid, ser_last, busy
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_data, ser_valid, ser_last, busy
  );
`endif

endinterface

// File: rtl/seq_mod3_residue.sv
// Synchronous 3-state tracker of the running value mod 3 for an MSB-first bit stream.
// residue_next exposes the value after absorbing bit_in, for same-edge decisions.
module seq_mod3_residue
  import seq_mod3_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  logic     en,
  input  logic     bit_in,
  output residue_t residue,
  output residue_t residue_next
);

  assign residue_next = residue_step(residue, bit_in);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      residue <= 2'd0;
    end else if (en) begin
      residue <= residue_next;
    end
  end

endmodule

// File: rtl/seq_mod3_serializer.sv
// Shifts a W-bit word out MSB-first followed by a 2-bit pad making the frame divisible by 3.
// Optional macro SEQ_MOD3_RES_OUT_EN adds res_out/res_valid reporting the payload residue.
module seq_mod3_serializer
  import seq_mod3_pkg::*;
#(
  parameter int W = 8
) (
  input logic                  clk,
  input logic                  rst,
  seq_mod3_serializer_if.slave bus
);

  localparam int BW = (W > 2) ? $clog2(W) : 1;

  state_t          state;
  logic [W-1:0]    sreg;
  logic [BW-1:0]   bit_idx;
  logic            pad_idx;
  residue_t        pad;
  residue_t        r;
  residue_t        r_next;
  residue_t        pad_new;
  logic            accept;

  assign bus.in_ready = !rst && ((state == IDLE) || (state == PAD && pad_idx));
  assign accept       = bus.in_valid && bus.in_ready;
  assign pad_new      = pad_lookup(r_next);

  // The bit currently on the line is the one folded into the residue.
  seq_mod3_residue u_residue (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept),
    .en           (state == SHIFT),
    .bit_in       (bus.ser_data),
    .residue      (r),
    .residue_next (r_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sreg          <= '0;
      bit_idx       <= '0;
      pad_idx       <= 1'b0;
      pad           <= 2'd0;
      bus.ser_data  <= 1'b0;
      bus.ser_valid <= 1'b0;
      bus.ser_last  <= 1'b0;
      bus.busy      <= 1'b0;
`ifdef SEQ_MOD3_RES_OUT_EN
      bus.res_out   <= 2'd0;
      bus.res_valid <= 1'b0;
`endif
    end else begin
`ifdef SEQ_MOD3_RES_OUT_EN
      bus.res_valid <= 1'b0;
`endif
      if (accept) begin
        // MSB goes straight to the line; sreg keeps the remaining bits.
        state         <= SHIFT;
        sreg          <= {bus.in_data[W-2:0], 1'b0};
        bit_idx       <= '0;
        pad_idx       <= 1'b0;
        bus.ser_data  <= bus.in_data[W-1];
        bus.ser_valid <= 1'b1;
        bus.ser_last  <= 1'b0;
        bus.busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            bus.ser_data  <= 1'b0;
            bus.ser_valid <= 1'b0;
            bus.ser_last  <= 1'b0;
            bus.busy      <= 1'b0;
          end
          SHIFT: begin
            if (bit_idx == BW'(W - 1)) begin
              state        <= PAD;
              pad_idx      <= 1'b0;
              pad          <= pad_new;
              bus.ser_data <= pad_new[1];
            end else begin
              bit_idx      <= bit_idx + BW'(1);
              bus.ser_data <= sreg[W-1];
              sreg         <= {sreg[W-2:0], 1'b0};
            end
          end
          PAD: begin
            if (!pad_idx) begin
              pad_idx       <= 1'b1;
              bus.ser_data  <= pad[0];
              bus.ser_last  <= 1'b1;
`ifdef SEQ_MOD3_RES_OUT_EN
              bus.res_out   <= r;
              bus.res_valid <= 1'b1;
`endif
            end else begin
              state         <= IDLE;
              pad_idx       <= 1'b0;
              bus.ser_data  <= 1'b0;
              bus.ser_valid <= 1'b0;
              bus.ser_last  <= 1'b0;
              bus.busy      <= 1'b0;
            end
          end
          default: begin
            state         <= IDLE;
            bus.ser_valid <= 1'b0;
            bus.ser_last  <= 1'b0;
            bus.busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
